// File: rtl/multicycle_cu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, states,
// ALU codes and datapath mux encodings.
package cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5
  } alu_op_e;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                          return S_R_EXEC;
      OP_LW, OP_SW:                      return S_MEM_ADDR;
      OP_BEQ, OP_BNE:                    return S_BRANCH;
      OP_J:                              return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
      default:                           return S_TRAP;
    endcase
  endfunction

  function automatic alu_op_e i_type_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cu_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access; expired flags the
// cycle on which the wait budget is exhausted and memory is still not ready.
module mem_wait_timer #(
  parameter int LIMIT = 15,
  parameter int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam bit             ENABLED = (LIMIT > 0);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && ENABLED && (r_count != LIMIT_C)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A zero limit disables the timeout entirely: waits become unbounded.
  assign o_expired = ENABLED && i_count && (r_count == LIMIT_C);

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: Moore sequencer for fetch/decode/execute/
// memory/write-back with a memory-ready handshake and sticky trap causes.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op_code,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal,
  output logic                mem_fault,
  output logic [3:0]          state_o
);

  state_e  r_state;
  state_e  w_next_state;
  logic    r_illegal;
  logic    r_mem_fault;
  logic    w_mem_state;
  logic    w_expired;
  logic    w_timer_clear;
  logic    w_timer_count;
  alu_op_e w_alu_code;

  assign w_mem_state   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timer_count = w_mem_state && !mem_ready;
  assign w_timer_clear = !w_mem_state || mem_ready || (w_next_state != r_state);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_count  (w_timer_count),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_expired)      w_next_state = S_TRAP;
        else if (mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE:   w_next_state = decode_next(op_code);
      S_MEM_ADDR: w_next_state = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (w_expired)      w_next_state = S_TRAP;
        else if (mem_ready) w_next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (w_expired)      w_next_state = S_TRAP;
        else if (mem_ready) w_next_state = S_FETCH;
      end
      S_R_EXEC:                                    w_next_state = S_R_WB;
      S_I_EXEC:                                    w_next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:  w_next_state = S_FETCH;
      S_TRAP:                                      w_next_state = S_TRAP;
      default:                                     w_next_state = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_illegal   <= 1'b0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_DECODE) && (w_next_state == S_TRAP)) r_illegal <= 1'b1;
      if (w_expired) r_mem_fault <= 1'b1;
    end
  end

  // Outputs decode the state register; rst forces every strobe low at once.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    instr_done = 1'b0;
    w_alu_code = ALU_ADD;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a  = 1'b1;
          w_alu_code = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          w_alu_code = i_type_alu_op(op_code);
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          w_alu_code = ALU_SUB;
          pc_src     = PC_ALUOUT;
          instr_done = 1'b1;
          pc_write   = ((op_code == OP_BEQ) && zero) || ((op_code == OP_BNE) && !zero);
        end
        S_JUMP: begin
          pc_src     = PC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
    alu_op = ALU_OP_W'(w_alu_code);
  end

  assign illegal   = r_illegal;
  assign mem_fault = r_mem_fault;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_cu.sv
// Scoreboarded bench for multicycle_cu: random instruction stream checked against
// a per-instruction reference model, plus directed reset, stall and trap cases.
module tb_multicycle_cu;
  import cu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default timeout of 15)
  logic       rst, zero, mem_ready;
  logic [5:0] op_code;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, instr_done, illegal, mem_fault;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  // Second DUT with a short timeout
  logic       rst_t, zero_t, mem_ready_t;
  logic [5:0] op_code_t;
  logic       pc_write_t, i_or_d_t, mem_read_t, mem_write_t, ir_write_t, reg_dst_t, mem_to_reg_t, reg_write_t;
  logic       alu_src_a_t, instr_done_t, illegal_t, mem_fault_t;
  logic [1:0] pc_src_t, alu_src_b_t;
  logic [2:0] alu_op_t;
  logic [3:0] state_o_t;

  multicycle_cu #(.ALU_OP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .mem_fault(mem_fault), .state_o(state_o)
  );

  multicycle_cu #(.ALU_OP_W(3), .MEM_TIMEOUT(2)) dut_t (
    .clk(clk), .rst(rst_t), .op_code(op_code_t), .zero(zero_t), .mem_ready(mem_ready_t),
    .pc_write(pc_write_t), .pc_src(pc_src_t), .i_or_d(i_or_d_t), .mem_read(mem_read_t),
    .mem_write(mem_write_t), .ir_write(ir_write_t), .reg_dst(reg_dst_t), .mem_to_reg(mem_to_reg_t),
    .reg_write(reg_write_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t), .alu_op(alu_op_t),
    .instr_done(instr_done_t), .illegal(illegal_t), .mem_fault(mem_fault_t), .state_o(state_o_t)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         cycles;
    int         exec_idx;
    logic [2:0] exec_alu;
    logic [1:0] exec_srcb;
    logic       exec_srca;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       mem_write;
    logic [2:0] done_alu;
  } exp_t;

  exp_t sb_q[$];

  // Instruction-level reference: base cycle counts plus one cycle per wait.
  function automatic exp_t model(input logic [5:0] op, input logic z, input int fw, input int mw);
    exp_t e;
    e = '{op: op, fw: fw, cycles: 0, exec_idx: fw + 2, exec_alu: 3'd0, exec_srcb: 2'd0,
          exec_srca: 1'b0, pc_write: 1'b0, pc_src: 2'd0, reg_write: 1'b0, mem_to_reg: 1'b0,
          reg_dst: 1'b0, mem_write: 1'b0, done_alu: 3'd0};
    case (op)
      6'b100011: begin
        e.cycles = 5 + fw + mw; e.exec_srcb = 2'd2; e.exec_srca = 1'b1;
        e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
      end
      6'b101011: begin
        e.cycles = 4 + fw + mw; e.exec_srcb = 2'd2; e.exec_srca = 1'b1; e.mem_write = 1'b1;
      end
      6'b000000: begin
        e.cycles = 4 + fw; e.exec_alu = 3'd2; e.exec_srca = 1'b1;
        e.reg_write = 1'b1; e.reg_dst = 1'b1;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        e.cycles = 4 + fw; e.exec_srcb = 2'd2; e.exec_srca = 1'b1; e.reg_write = 1'b1;
        e.exec_alu = (op == 6'b001100) ? 3'd3 : (op == 6'b001101) ? 3'd4 :
                     (op == 6'b001010) ? 3'd5 : 3'd0;
      end
      6'b000100, 6'b000101: begin
        e.cycles = 3 + fw; e.exec_alu = 3'd1; e.exec_srca = 1'b1; e.done_alu = 3'd1;
        e.pc_src = 2'b01;
        e.pc_write = (op == 6'b000100) ? z : ~z;
      end
      default: begin
        e.cycles = 3 + fw; e.pc_src = 2'b10; e.pc_write = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: walks each instruction cycle by cycle and retires it on instr_done.
  bit sb_active = 1'b0;
  int idx = 0;
  always @(negedge clk) begin
    if (sb_active) begin
      if (sb_q.size() == 0) begin
        if (instr_done) check("unexpected_done", 32'(instr_done), 32'd0);
      end else begin
        if (idx <= sb_q[0].fw) check("fetch_mem_read", 32'(mem_read), 32'd1);
        if (idx == sb_q[0].exec_idx) begin
          check("exec_alu_op", 32'(alu_op), 32'(sb_q[0].exec_alu));
          check("exec_alu_src_b", 32'(alu_src_b), 32'(sb_q[0].exec_srcb));
          check("exec_alu_src_a", 32'(alu_src_a), 32'(sb_q[0].exec_srca));
        end
        if (instr_done) begin
          exp_t e;
          e = sb_q.pop_front();
          check("cycles", 32'(idx + 1), 32'(e.cycles));
          check("done_pc_write", 32'(pc_write), 32'(e.pc_write));
          check("done_pc_src", 32'(pc_src), 32'(e.pc_src));
          check("done_reg_write", 32'(reg_write), 32'(e.reg_write));
          check("done_mem_to_reg", 32'(mem_to_reg), 32'(e.mem_to_reg));
          check("done_reg_dst", 32'(reg_dst), 32'(e.reg_dst));
          check("done_mem_write", 32'(mem_write), 32'(e.mem_write));
          check("done_alu_op", 32'(alu_op), 32'(e.done_alu));
          $display("[TB] instr op=%06b fetch_wait=%0d cycles=%0d retired", e.op, e.fw, idx + 1);
          idx = 0;
        end else begin
          check("ir_write", 32'(ir_write), 32'(idx == sb_q[0].fw));
          check("pc_write", 32'(pc_write), 32'(idx == sb_q[0].fw));
          check("reg_write_idle", 32'(reg_write), 32'd0);
          idx++;
          if (idx > 40) begin
            check("done_timeout", 32'(idx), 32'(sb_q[0].cycles));
            void'(sb_q.pop_front());
            idx = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; op_code = 6'b000000;
    rst_t = 1'b1; zero_t = 1'b0; mem_ready_t = 1'b0; op_code_t = 6'b000000;
    tick(); tick();

    // Reset asserted in the middle of an R-type
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("r_exec_state", 32'(state_o), 32'(S_R_EXEC));
    rst = 1'b1;
    #1;
    check("rst_state", 32'(state_o), 32'(S_FETCH));
    check("rst_strobes", {26'd0, pc_write, ir_write, mem_read, mem_write, reg_write, instr_done}, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_flags", {30'd0, illegal, mem_fault}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_read", 32'(mem_read), 32'd1);

    // FETCH stalled three cycles
    rst = 1'b1; mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ir_write", 32'(ir_write), 32'd0);
      check("stall_state", 32'(state_o), 32'(S_FETCH));
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("stall_end_ir_write", 32'(ir_write), 32'd1);
    check("stall_end_state", 32'(state_o), 32'(S_FETCH));
    tick();
    @(negedge clk);
    check("stall_decode", 32'(state_o), 32'(S_DECODE));

    // Illegal opcode traps and stays trapped
    rst = 1'b1; op_code = 6'b111111;
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("illegal_decode", 32'(state_o), 32'(S_DECODE));
    tick();
    @(negedge clk);
    check("illegal_trap", 32'(state_o), 32'(S_TRAP));
    check("illegal_flag", 32'(illegal), 32'd1);
    check("illegal_no_fault", 32'(mem_fault), 32'd0);
    repeat (20) tick();
    @(negedge clk);
    check("illegal_sticky", 32'(illegal), 32'd1);
    check("trap_held", 32'(state_o), 32'(S_TRAP));
    check("trap_strobes", {28'd0, mem_read, mem_write, reg_write, pc_write}, 32'd0);
    rst = 1'b1;
    #1;
    check("illegal_cleared", 32'(illegal), 32'd0);

    // Random instruction stream
    tick();
    rst = 1'b0;
    sb_active = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      int         fw, mw, ms;
      logic       z;
      exp_t       e;
      logic       sched[$];
      op = ops[$urandom_range(0, 9)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      z  = 1'($urandom_range(0, 1));
      e  = model(op, z, fw, mw);
      sb_q.push_back(e);
      sched.delete();
      for (int i = 0; i < e.cycles; i++) sched.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < fw; i++) sched[i] = 1'b0;
      sched[fw] = 1'b1;
      if (op == 6'b100011 || op == 6'b101011) begin
        ms = fw + 3;
        for (int i = 0; i < mw; i++) sched[ms + i] = 1'b0;
        sched[ms + mw] = 1'b1;
      end
      op_code = op;
      zero = z;
      for (int i = 0; i < sched.size(); i++) begin
        mem_ready = sched[i];
        tick();
      end
    end
    sb_active = 1'b0;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // Timeout on the short-limit instance
    rst_t = 1'b0;
    repeat (3) @(negedge clk);
    check("to2_waiting", 32'(state_o_t), 32'(S_FETCH));
    check("to2_no_fault_yet", 32'(mem_fault_t), 32'd0);
    @(negedge clk);
    check("to2_trap", 32'(state_o_t), 32'(S_TRAP));
    check("to2_fault", 32'(mem_fault_t), 32'd1);
    check("to2_not_illegal", 32'(illegal_t), 32'd0);

    // Timeout boundary on the default instance
    rst = 1'b1; mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (16) @(negedge clk);
    check("to15_waiting", 32'(state_o), 32'(S_FETCH));
    check("to15_no_fault_yet", 32'(mem_fault), 32'd0);
    @(negedge clk);
    check("to15_trap", 32'(state_o), 32'(S_TRAP));
    check("to15_fault", 32'(mem_fault), 32'd1);
    rst = 1'b1;
    #1;
    check("to15_fault_cleared", 32'(mem_fault), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle MIPS control unit. It replaces the single-cycle combinational decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It waits on a memory-ready handshake and traps on illegal opcodes or memory timeouts. It sits between the instruction register (op_code source), the ALU zero flag and the shared datapath muxes and enables.

## Interface
- ALU_OP_W, 3: width of alu_op; must be ≥3.
- MEM_TIMEOUT, 15: max consecutive wait cycles in a memory state; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op_code  in  6  opcode from the IR; stable from the cycle after FETCH completes.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- i_or_d  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read, mem_write  out  1  memory strobes.
- ir_write  out  1  IR load.
- reg_dst  out  1  register write address: 0 rt, 1 rd.
- mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B input: 00 rt, 01 const 4, 10 sign-extended immediate, 11 immediate<<2.
- alu_op  out  ALU_OP_W  zero-extended code: 0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR, 5 SLT.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
- illegal, mem_fault  out  1  sticky trap causes.
- state_o  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
- FETCH
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Advances to DECODE only when mem_ready=1.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD; this precomputes the branch target.
  - Next state by opcode:
    - 000000 → R_EXEC.
    - 100011 / 101011 → MEM_ADDR.
    - 000100 / 000101 → BRANCH.
    - 000010 → JUMP.
    - 001000 / 001100 / 001101 / 001010 → I_EXEC.
    - Anything else → TRAP.
- MEM_ADDR
  - Outputs: alu_src_a=1, alu_src_b=10, ADD.
  - lw → MEM_RD; sw → MEM_WR.
- MEM_RD
  - Outputs: mem_read=1, i_or_d=1.
  - Waits for mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_done.
- MEM_WR
  - Outputs: mem_write=1, i_or_d=1.
  - Waits for mem_ready; instr_done on the ready cycle.
- R_EXEC: alu_src_a=1, alu_src_b=00, FUNCT. Then R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; instr_done.
- I_EXEC
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op by opcode: addi→ADD, andi→AND, ori→OR, slti→SLT.
  - Then I_WB: reg_write=1, reg_dst=0; instr_done.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, SUB, pc_src=01; instr_done.
  - pc_write = (beq & zero) | (bne & ~zero).
- JUMP: pc_src=10, pc_write=1; instr_done.
- Every instr_done state returns to FETCH.
- Unlisted outputs are 0 in every state.
- Timeout
  - A wait counter (width clog2(MEM_TIMEOUT+1)) counts consecutive mem_ready=0 cycles in FETCH, MEM_RD and MEM_WR.
  - It clears on every state change and on mem_ready=1.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: mem_fault←1, → TRAP.
- TRAP
  - All strobes 0. It is held until reset.
  - illegal is set on entry from DECODE; mem_fault is set on entry via timeout.

## Timing
- Outputs are combinational from the state register. pc_write, ir_write and mem-state instr_done also depend on zero or mem_ready, so they are Mealy-gated.
- Reset:
  - state=FETCH and wait counter=0 immediately.
  - illegal=0 and mem_fault=0.
  - While rst=1, all strobes and enables are forced 0 and alu_op=0.
- Cycle counts with mem_ready always 1:
  - lw 5; sw 4; R 4; I-type 4; beq/bne 3; j 3.
  - Each wait cycle adds 1.
- mem_ready is sampled only in memory states; it is ignored elsewhere.
- Reset asserted mid-instruction aborts it. No write strobe is asserted after rst rises.
- MEM_TIMEOUT=0: waits are unbounded and mem_fault never sets.

## Structure
- Shared package cu_pkg holds:
  - Opcode constants.
  - State enum (4 bits).
  - alu_op codes.
  - alu_src_b and pc_src encodings.
- One sub-module, mem_wait_timer: parametrised counter with clear and count inputs and an expired output.

## Test plan
- Reset: assert rst mid-R_EXEC → state_o=FETCH immediately, all strobes 0, illegal=0 and mem_fault=0. After release, mem_read=1.
- lw (100011), mem_ready=1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. reg_write=1 and mem_to_reg=1 in cycle 5; instr_done exactly once.
- beq (000100) with zero=1 → pc_write=1 and pc_src=01 in cycle 3. Same with zero=0 → pc_write=0. bne inverts both outcomes.
- ori (001101) → I_EXEC alu_op=4, alu_src_b=10; I_WB reg_write=1, reg_dst=0.
- FETCH with mem_ready low for 3 cycles, then high → stays in FETCH 4 cycles; ir_write pulses only on the 4th. With MEM_TIMEOUT=2 and ready held low → TRAP, mem_fault=1.
- Opcode 111111 → DECODE, then TRAP; illegal=1 and stays 1 through 20 idle cycles until reset.
